// File: rtl/uart_tx_frame_generator_pkg.sv
// uart_tx_frame_generator_pkg
// Shared definitions for the UART transmit frame generator: FSM state
// encodings, LCR word-length codes, the default oversample ratio, the stop
// length constants, and small helpers for parity and stop-length arithmetic.
// No ports (package).

package uart_tx_frame_generator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int OVERSAMPLE_DEF = 16;

    // Stop lengths expressed in half-bit periods, so 1.5 stop bits stays integral.
    localparam int STOP_HALVES_1   = 2;
    localparam int STOP_HALVES_1P5 = 3;
    localparam int STOP_HALVES_2   = 4;

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        case (wls)
            WLS_5:   word_mask = 8'h1F;
            WLS_6:   word_mask = 8'h3F;
            WLS_7:   word_mask = 8'h7F;
            default: word_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       eps,
                                        input logic       sp);
        logic x;
        x = ^(data & word_mask(wls));
        if (sp)
            parity_bit = ~eps;
        else if (eps)
            parity_bit = x;
        else
            parity_bit = ~x;
    endfunction

    function automatic int stop_ticks(input int         os,
                                      input logic       stb,
                                      input logic [1:0] wls);
        int halves;
        if (!stb)
            halves = STOP_HALVES_1;
        else if (wls == WLS_5)
            halves = STOP_HALVES_1P5;
        else
            halves = STOP_HALVES_2;
        stop_ticks = (os / 2) * halves;
    endfunction

endpackage

// File: rtl/uart_tx_frame_generator_counter_en.sv
// counter_en
// Generic enabled up-counter with synchronous clear; clear wins over enable.
// Ports:
//   clk           - clock, rising edge
//   reset_b       - asynchronous active-low reset, clears count
//   en            - increment by one when high
//   counter_clear - synchronous clear to zero
//   count         - current count value

module counter_en #(
    parameter int COUNTER_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     en,
    input  logic                     counter_clear,
    output logic [COUNTER_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            count <= '0;
        else if (counter_clear)
            count <= '0;
        else if (en)
            count <= count + COUNTER_WIDTH'(1);
    end

endmodule

// File: rtl/uart_tx_frame_generator.sv
// uart_tx_frame_generator
// Transmit frame engine: takes one word over a valid/ready handshake and
// serializes start, 5-8 data bits (LSB first), optional parity and
// 1/1.5/2 stop bits onto txd, timed by the oversampled baud tick.
// Ports:
//   pclk, preset        - clock and asynchronous active-high reset
//   baud_tick           - one-pclk pulse at OVERSAMPLE x baud rate
//   tx_data/tx_valid    - word offered for transmission
//   tx_ready            - idle, a word may be accepted this cycle
//   wls,pen,eps,sp,stb  - line control, latched with the word
//   bc                  - break control, forces txd low (registered)
//   txd                 - registered serial output
//   tx_busy             - frame in progress
//   tx_done             - one-cycle pulse as the frame completes
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | line marking, ready for a word
// START   | start bit (low) for one bit period
// DATA    | data bits LSB first, bit_cnt 0..wls+4
// PARITY  | parity bit for one bit period (pen only)
// STOP    | stop bits (high), 1, 1.5 or 2 bit periods

module uart_tx_frame_generator
    import uart_tx_frame_generator_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_W     = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        wls,
    input  logic              pen,
    input  logic              eps,
    input  logic              sp,
    input  logic              stb,
    input  logic              bc,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_done
);

    // Wide enough for the longest stop period (2 bit periods).
    localparam int TICK_W = $clog2(2 * OVERSAMPLE);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_last;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        wls_q;
    logic              pen_q;
    logic              eps_q;
    logic              sp_q;
    logic              stb_q;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_last;
    logic [2:0]        bit_idx_next;
    logic              accept;
    logic              bit_end;
    logic              data_leave;
    logic              done_next;
    logic              line_next;
    logic              txd_next;
    logic              par_q;
    logic              preset_b;

    assign preset_b = ~preset;
    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = (state != ST_IDLE);
    assign bit_last = {1'b0, wls_q} + 3'd4;
    assign par_q    = parity_bit(data_q, wls_q, eps_q, sp_q);

    // The stop period is the only one that is not exactly one bit long.
    always_comb begin
        tick_last = TICK_W'(OVERSAMPLE - 1);
        if (state == ST_STOP)
            tick_last = TICK_W'(stop_ticks(OVERSAMPLE, stb_q, wls_q) - 1);
    end

    assign bit_end = baud_tick && (state != ST_IDLE) && (tick_cnt == tick_last);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            tick_cnt <= '0;
        else if (state == ST_IDLE || bit_end)
            tick_cnt <= '0;
        else if (baud_tick)
            tick_cnt <= tick_cnt + TICK_W'(1);
    end

    counter_en #(
        .COUNTER_WIDTH (3)
    ) u_bit_cnt (
        .clk           (pclk),
        .reset_b       (preset_b),
        .en            (bit_end && (state == ST_DATA)),
        .counter_clear (data_leave),
        .count         (bit_cnt)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        data_leave = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    accept     = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == bit_last)) begin
                    data_leave = 1'b1;
                    state_next = pen_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end)
                    state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // txd is registered, so the line level is derived from where the FSM is
    // going, including the data bit index it will hold after this edge.
    assign bit_idx_next = (state == ST_DATA && bit_end) ? bit_cnt + 3'd1 : bit_cnt;

    always_comb begin
        line_next = 1'b1;
        case (state_next)
            ST_START:  line_next = 1'b0;
            ST_DATA:   line_next = data_q[bit_idx_next];
            ST_PARITY: line_next = par_q;
            default:   line_next = 1'b1;
        endcase
    end

    assign txd_next = bc ? 1'b0 : line_next;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            txd     <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            txd     <= txd_next;
            tx_done <= done_next;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            data_q <= '0;
            wls_q  <= WLS_5;
            pen_q  <= 1'b0;
            eps_q  <= 1'b0;
            sp_q   <= 1'b0;
            stb_q  <= 1'b0;
        end else if (accept) begin
            data_q <= tx_data;
            wls_q  <= wls;
            pen_q  <= pen;
            eps_q  <= eps;
            sp_q   <= sp;
            stb_q  <= stb;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_generator.sv
module tb_uart_tx_frame_generator;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sp;
        logic       stb;
        logic       tick_all;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int   exp_ticks;
        logic exp_par;
    } vec_t;

    logic       pclk = 1'b0;
    logic       preset;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] wls;
    logic       pen, eps, sp, stb, bc;
    logic       txd, tx_busy, tx_done;

    int n_total = 0;
    int n_pass  = 0;
    int done_cnt = 0;
    logic exp_lvl [0:255];

    uart_tx_frame_generator #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
        .pclk(pclk), .preset(preset), .baud_tick(baud_tick),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wls(wls), .pen(pen), .eps(eps), .sp(sp), .stb(stb), .bc(bc),
        .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (tx_done === 1'b1) done_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic cfg_t mk(input logic [7:0] d, input logic [1:0] w, input logic p,
                                input logic e, input logic s, input logic st, input logic ta);
        cfg_t c;
        c.data = d; c.wls = w; c.pen = p; c.eps = e; c.sp = s; c.stb = st; c.tick_all = ta;
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        return mk(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0));
    endfunction

    // Reference: the line level for every baud tick of the frame.
    task automatic build_model(input cfg_t c, output int total);
        int n, idx, stop;
        logic p;
        n = 5 + int'(c.wls);
        idx = 0;
        for (int i = 0; i < OS; i++) exp_lvl[idx++] = 1'b0;
        p = 1'b0;
        for (int b = 0; b < n; b++) begin
            p = p ^ c.data[b];
            for (int i = 0; i < OS; i++) exp_lvl[idx++] = c.data[b];
        end
        if (c.pen) begin
            if (c.sp) p = ~c.eps;
            else if (!c.eps) p = ~p;
            for (int i = 0; i < OS; i++) exp_lvl[idx++] = p;
        end
        stop = !c.stb ? OS : (n == 5 ? (3 * OS) / 2 : 2 * OS);
        for (int i = 0; i < stop; i++) exp_lvl[idx++] = 1'b1;
        total = idx;
    endtask

    task automatic present(input cfg_t c);
        tx_data = c.data; wls = c.wls; pen = c.pen; eps = c.eps; sp = c.sp; stb = c.stb;
        tx_valid = 1'b1; bc = 1'b0;
        baud_tick = 1'($urandom);
    endtask

    // Called at the negedge where the word is offered; returns at the tx_done cycle.
    task automatic frame(input cfg_t c, input bit chain, input cfg_t nc,
                         input int bc_lo, input int bc_hi,
                         output int ticks, output int cycles, output logic par_seen);
        int total, k, cyc, n, par_idx;
        logic bcp;
        logic [3:0] e;
        bit got_par;
        build_model(c, total);
        n = 5 + int'(c.wls);
        par_idx = OS * (1 + n);
        k = 0; cyc = 0; bcp = bc; par_seen = 1'b0; got_par = 0;
        forever begin
            @(negedge pclk);
            if (k == total) e = {~bcp, 1'b0, 1'b1, 1'b1};
            else e = {bcp ? 1'b0 : exp_lvl[k], 1'b1, 1'b0, 1'b0};
            chk("frame_outputs", {28'd0, txd, tx_busy, tx_ready, tx_done}, {28'd0, e});
            if (c.pen && !got_par && k == par_idx) begin
                par_seen = txd;
                got_par = 1;
            end
            if (k == total) begin
                bc = 1'b0;
                if (chain) present(nc);
                else tx_valid = 1'b0;
                break;
            end
            if (cyc >= 4000) begin
                n_total++;
                $display("FAIL frame_timeout: got %0d ticks expected %0d", k, total);
                bc = 1'b0; tx_valid = 1'b0;
                break;
            end
            tx_valid = chain;
            tx_data = 8'($urandom); wls = 2'($urandom); pen = 1'($urandom);
            eps = 1'($urandom); sp = 1'($urandom); stb = 1'($urandom);
            bc = (cyc >= bc_lo && cyc < bc_hi);
            bcp = bc;
            baud_tick = c.tick_all ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (baud_tick) k++;
            cyc++;
        end
        ticks = k;
        cycles = cyc;
    endtask

    vec_t vecs [9];

    initial begin
        int t, cy, dc;
        logic p;
        cfg_t cur, nxt, dummy;
        bit ch;

        vecs[0] = '{c: mk(8'hA5, 2'b11, 0, 0, 0, 0, 1), exp_ticks: 160, exp_par: 1'b0};
        vecs[1] = '{c: mk(8'hC1, 2'b10, 1, 1, 0, 0, 1), exp_ticks: 160, exp_par: 1'b0};
        vecs[2] = '{c: mk(8'hC1, 2'b10, 1, 0, 0, 0, 1), exp_ticks: 160, exp_par: 1'b1};
        vecs[3] = '{c: mk(8'hC1, 2'b10, 1, 1, 1, 0, 1), exp_ticks: 160, exp_par: 1'b0};
        vecs[4] = '{c: mk(8'h1F, 2'b00, 0, 0, 0, 1, 1), exp_ticks: 120, exp_par: 1'b0};
        vecs[5] = '{c: mk(8'h1F, 2'b11, 0, 0, 0, 1, 1), exp_ticks: 176, exp_par: 1'b0};
        vecs[6] = '{c: mk(8'h2A, 2'b01, 1, 0, 1, 0, 1), exp_ticks: 144, exp_par: 1'b1};
        vecs[7] = '{c: mk(8'h6B, 2'b01, 1, 1, 0, 1, 0), exp_ticks: 160, exp_par: 1'b0};
        vecs[8] = '{c: mk(8'h13, 2'b00, 1, 0, 0, 1, 0), exp_ticks: 136, exp_par: 1'b0};
        dummy = mk(8'h00, 2'b11, 0, 0, 0, 0, 1);

        preset = 1'b1; baud_tick = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        wls = 2'b00; pen = 0; eps = 0; sp = 0; stb = 0; bc = 0;
        #1;
        chk("reset_outputs", {28'd0, txd, tx_busy, tx_ready, tx_done}, 32'b1010);
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        baud_tick = 1'b1;
        @(negedge pclk);
        chk("post_reset_idle", {28'd0, txd, tx_busy, tx_ready, tx_done}, 32'b1010);

        // table vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge pclk);
            present(vecs[i].c);
            frame(vecs[i].c, 0, dummy, -1, -1, t, cy, p);
            chk("vec_frame_ticks", t, vecs[i].exp_ticks);
            if (vecs[i].c.tick_all) chk("vec_frame_cycles", cy, vecs[i].exp_ticks);
            if (vecs[i].c.pen) chk("vec_parity", {31'd0, p}, {31'd0, vecs[i].exp_par});
            @(negedge pclk);
            chk("done_single_cycle", {28'd0, txd, tx_busy, tx_ready, tx_done}, 32'b1010);
        end

        // break held for 40 cycles in the middle of an 8N1 frame
        @(negedge pclk);
        present(vecs[0].c);
        frame(vecs[0].c, 0, dummy, 60, 100, t, cy, p);
        chk("break_done_cycle", cy, 160);

        // back-to-back words with tx_valid held high
        @(negedge pclk);
        dc = done_cnt;
        cur = mk(8'h5A, 2'b11, 0, 0, 0, 0, 1);
        nxt = mk(8'h33, 2'b10, 1, 0, 0, 0, 1);
        present(cur);
        frame(cur, 1, nxt, -1, -1, t, cy, p);
        chk("b2b_first_cycles", cy, 160);
        frame(nxt, 0, dummy, -1, -1, t, cy, p);
        chk("b2b_second_cycles", cy, 160);
        repeat (5) @(negedge pclk);
        chk("b2b_done_pulses", done_cnt - dc, 2);

        // randomized frames, some chained
        @(negedge pclk);
        cur = rand_cfg();
        present(cur);
        for (int i = 0; i < 24; i++) begin
            nxt = rand_cfg();
            ch = (i < 23) && ($urandom_range(0, 1) == 1);
            frame(cur, ch, nxt, -1, -1, t, cy, p);
            if (!ch && i < 23) begin
                @(negedge pclk);
                present(nxt);
            end
            cur = nxt;
        end

        // reset asserted during data bit 3
        repeat (2) @(negedge pclk);
        cur = mk(8'h3C, 2'b11, 0, 0, 0, 0, 1);
        present(cur);
        for (int i = 0; i < 67; i++) begin
            @(negedge pclk);
            tx_valid = 1'b0;
            baud_tick = 1'b1;
        end
        chk("pre_reset_busy", {31'd0, tx_busy}, 32'd1);
        dc = done_cnt;
        preset = 1'b1;
        #1;
        chk("midframe_reset_outputs", {28'd0, txd, tx_busy, tx_ready, tx_done}, 32'b1010);
        @(negedge pclk);
        preset = 1'b0;
        repeat (200) @(negedge pclk);
        chk("no_done_after_reset", done_cnt - dc, 0);
        chk("idle_after_reset", {28'd0, txd, tx_busy, tx_ready, tx_done}, 32'b1010);
        cur = mk(8'hE7, 2'b11, 1, 1, 0, 0, 1);
        present(cur);
        frame(cur, 0, dummy, -1, -1, t, cy, p);
        chk("after_reset_frame_cycles", cy, 176);

        repeat (3) @(negedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
